// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and registers
// the returned word into the IF/ID latch. Redirects squash; bad fetch PCs halt.
module instr_fetch #(
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_err,
  output logic [31:0] pc
);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        redirect;
  logic        next_err;

  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    jump_target   = {branch_base[31:28], jump_index, 2'b00};
    branch_target = branch_base + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    redirect      = jump | branch_taken;

    if (jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
    else if (stall)        next_pc = pc_q;
    else                   next_pc = pc_plus4;

    next_err = (next_pc > PC_MAX) || (next_pc[1:0] != 2'b00);

    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = 32'h0;
          if (next_err) state_d = ST_HALT;
          else          pc_d    = next_pc;
        end else if (!stall) begin
          // The current PC is legal, so its word is latched even if PC+4 is not.
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (next_err) state_d = ST_HALT;
          else          pc_d    = pc_plus4;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // The sticky error flag is the HALT state itself, which also exposes the FSM.
  assign fetch_err   = (state_q == ST_HALT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a driver pushes expected IF/ID latches into a
// queue, a monitor pops them whenever a new live instruction appears.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_err;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  instr_fetch #(.IMEM_BYTES(256), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_base(branch_base),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .fetch_err(fetch_err), .pc(pc)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Instruction memory model
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0)      return 32'h8C08_0000;
    else if (addr == 32'h4) return 32'h8C09_0001;
    else                    return 32'hA5A5_0000 | {16'h0, addr[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  // Driver tasks
  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_base = 32'h0; branch_offset = 16'h0; jump_index = 26'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [31:0] exp_pc,
                             input logic exp_valid, input logic exp_err);
    check({name, " pc"}, pc, exp_pc);
    check({name, " imem_addr"}, imem_addr, exp_pc);
    check({name, " valid"}, {31'h0, if_id_valid}, {31'h0, exp_valid});
    check({name, " fetch_err"}, {31'h0, fetch_err}, {31'h0, exp_err});
  endtask

  // Scoreboard monitor: a live latch that differs from last cycle is a new fetch
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc4   = 32'h0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (if_id_valid === 1'b1 &&
        (!prev_valid || if_id_instr !== prev_instr || if_id_pc4 !== prev_pc4)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got instr %h pc4 %h, none expected", if_id_instr, if_id_pc4);
      end else begin
        e = exp_q.pop_front();
        if (if_id_instr !== e[63:32] || if_id_pc4 !== e[31:0]) begin
          errors++;
          $display("FAIL sb_latch: got instr %h pc4 %h expected instr %h pc4 %h",
                   if_id_instr, if_id_pc4, e[63:32], e[31:0]);
        end
      end
    end
    prev_valid = if_id_valid;
    prev_instr = if_id_instr;
    prev_pc4   = if_id_pc4;
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    check_state("reset", 32'h0, 1'b0, 1'b0);
    check("reset instr", if_id_instr, 32'h0);
    check("reset pc4", if_id_pc4, 32'h0);
    reset = 1'b0;

    // Two sequential fetches
    expect_fetch(32'h8C08_0000, 32'h4);
    step();
    check_state("seq1", 32'h4, 1'b1, 1'b0);
    expect_fetch(32'h8C09_0001, 32'h8);
    step();
    check_state("seq2", 32'h8, 1'b1, 1'b0);

    // Jump to word 2 squashes, then address 8 is fetched
    jump = 1'b1; jump_index = 26'd2; branch_base = 32'h38;
    step();
    check_state("jump", 32'h8, 1'b0, 1'b0);
    check("jump squash instr", if_id_instr, 32'h0);
    clear_inputs();
    expect_fetch(32'hA5A5_0008, 32'hC);
    step();
    check_state("after jump", 32'hC, 1'b1, 1'b0);

    // Backward branch, then the same with a jump that wins
    branch_taken = 1'b1; branch_base = 32'h2C; branch_offset = 16'hFFFC;
    step();
    check_state("branch back", 32'h1C, 1'b0, 1'b0);
    jump = 1'b1; jump_index = 26'd5;
    step();
    check_state("jump wins", 32'h14, 1'b0, 1'b0);
    clear_inputs();

    // Get to pc=0x10 with a live latch, then stall three cycles
    branch_taken = 1'b1; branch_base = 32'h10; branch_offset = 16'hFFFF;
    step();
    check_state("branch to C", 32'hC, 1'b0, 1'b0);
    clear_inputs();
    expect_fetch(32'hA5A5_000C, 32'h10);
    step();
    check_state("fetch C", 32'h10, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("stall", 32'h10, 1'b1, 1'b0);
      check("stall instr", if_id_instr, 32'hA5A5_000C);
      check("stall pc4", if_id_pc4, 32'h10);
    end
    branch_taken = 1'b1; branch_base = 32'h4; branch_offset = 16'h0001;
    step();
    check_state("stall+branch", 32'h8, 1'b0, 1'b0);
    clear_inputs();

    // Run off the top of memory
    jump = 1'b1; jump_index = 26'd62;
    step();
    check_state("jump F8", 32'hF8, 1'b0, 1'b0);
    clear_inputs();
    expect_fetch(32'hA5A5_00F8, 32'hFC);
    step();
    check_state("fetch F8", 32'hFC, 1'b1, 1'b0);
    expect_fetch(32'hA5A5_00FC, 32'h100);
    step();
    check_state("fetch FC err", 32'hFC, 1'b1, 1'b1);
    step();
    check_state("halt drop", 32'hFC, 1'b0, 1'b1);
    jump = 1'b1; jump_index = 26'd2; branch_taken = 1'b1; branch_base = 32'h4;
    stall = 1'b1;
    step();
    check_state("halt ignores", 32'hFC, 1'b0, 1'b1);
    clear_inputs();
    step();
    check_state("halt seq ignored", 32'hFC, 1'b0, 1'b1);

    // Reset out of HALT; legal branch then an out-of-range jump
    reset = 1'b1;
    jump = 1'b1; jump_index = 26'd9;
    step();
    check_state("reset from halt", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    clear_inputs();
    branch_taken = 1'b1; branch_base = 32'h4; branch_offset = 16'h0001;
    step();
    check_state("legal branch", 32'h8, 1'b0, 1'b0);
    clear_inputs();
    jump = 1'b1; jump_index = 26'd64;
    step();
    check_state("jump range err", 32'h8, 1'b0, 1'b1);
    clear_inputs();

    // Misaligned branch target
    reset = 1'b1;
    step();
    reset = 1'b0;
    branch_taken = 1'b1; branch_base = 32'h2; branch_offset = 16'h0;
    step();
    check_state("misaligned err", 32'h0, 1'b0, 1'b1);
    clear_inputs();

    // Normal fetch resumes after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_fetch(32'h8C08_0000, 32'h4);
    step();
    check_state("resume", 32'h4, 1'b1, 1'b0);
    stall = 1'b1;
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected fetches never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC owner and fetch stage that drives the byte-addressed instruction memory's read address.
- Registers the returned 32-bit word into an IF/ID latch for the decode stage.
- Applies branch and jump redirects from downstream, with squash and stall.
- Detects out-of-range or misaligned fetch addresses and halts in a sticky error state.

Parameters:
IMEM_BYTES, 256, instruction memory size in bytes; legal fetch PC is 0..IMEM_BYTES-4.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
imem_addr  output  32  read address to instruction memory; equals current pc.
imem_data  input  32  instruction word returned combinationally for imem_addr.
stall  input  1  hold PC and IF/ID latch.
branch_taken  input  1  redirect to branch target this cycle.
branch_base  input  32  PC+4 of the branch instruction, from IF/ID.
branch_offset  input  16  signed word offset.
jump  input  1  redirect to jump target this cycle.
jump_index  input  26  word index of the jump target.
if_id_instr  output  32  latched instruction.
if_id_pc4  output  32  latched PC+4 of that instruction.
if_id_valid  output  1  latch holds a live instruction.
fetch_err  output  1  sticky error; block is halted.
pc  output  32  current fetch PC, for debug.

Behaviour:
- One clock and one reset: clk, with synchronous active-high reset. All state updates on the rising clk edge.
- Reset values: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_err=0, state=RUN.
- imem_addr = pc, combinational. imem_data is sampled in the same cycle, so instruction latency from PC to if_id_instr is 1 clk.
- States: RUN and HALT.
  - HALT is entered from RUN on any error condition.
  - HALT is left only by reset.
- RUN priority, highest first: reset > jump > branch_taken > stall > sequential.
- jump:
  - pc <= {branch_base[31:28], jump_index, 2'b00}.
  - Squash: if_id_valid <= 0, if_id_instr <= 0.
- branch_taken (jump=0):
  - pc <= branch_base + ({{14{branch_offset[15]}}, branch_offset, 2'b00}).
  - Squash as for jump.
- Redirect overrides stall: a redirect with stall=1 still updates pc and squashes.
- Simultaneous jump and branch_taken: jump wins; the branch is ignored.
- stall (no redirect): pc, if_id_instr, if_id_pc4 and if_id_valid hold.
- Sequential: pc <= pc+4, if_id_instr <= imem_data, if_id_pc4 <= pc+4, if_id_valid <= 1.
- Arithmetic is 32-bit modulo 2^32. The range check below catches wrap before it matters.
- Error conditions, checked on the next-PC value that would be loaded:
  - out of range: next_pc > IMEM_BYTES-4, or
  - misaligned: next_pc[1:0] != 0.
- On an error:
  - fetch_err <= 1.
  - state <= HALT.
  - pc holds its old value.
  - if_id_valid <= 0.
  - A sequential fetch that errors still latches the current legal instruction (if_id_instr, if_id_pc4, if_id_valid=1). Only pc is frozen, and the next cycle drops to if_id_valid=0.
- HALT:
  - pc frozen, if_id_valid=0, fetch_err=1.
  - stall, jump and branch inputs are ignored.
- Reset mid-operation: reset asserted in any state or cycle restores all reset values on that edge, regardless of other inputs.

Test Plan:
- Reset, imem returns 32'h8C08_0000 at 0 and 32'h8C09_0001 at 4 → cycle 1: if_id_instr=8C080000, if_id_pc4=4, valid=1; cycle 2: if_id_instr=8C090001, if_id_pc4=8; pc=8.
- jump=1, jump_index=26'd2, branch_base=32'h38 → next pc=8, if_id_valid=0; following cycle fetches address 8.
- branch_taken=1, branch_base=32'h2C, branch_offset=16'hFFFC → pc=32'h1C, if_id_valid=0. Same stimulus with jump=1, jump_index=5 → pc=32'h14 (jump wins).
- pc=0x10, stall=1 for 3 cycles → pc stays 0x10 and the IF/ID latch is unchanged. stall=1 with branch_taken=1 → redirect still taken.
- Sequential run from pc=0xF8 with IMEM_BYTES=256 → 0xF8 latched; at pc=0xFC the instruction is latched and fetch_err=1, pc stays 0xFC, valid=0 next cycle. Redirect inputs are then ignored until reset.
- branch_base=4, branch_offset=1 (target 8, legal) vs a jump target over 252 (jump_index=26'd64 → 0x100) → error, HALT. Reset asserted in HALT → pc=0, fetch_err=0, normal fetch resumes.
